// File: rtl/population_fitness_evaluator.sv
// population_fitness_evaluator: runs one generation through the processing SM, reduces error sums to fitness, tracks the best chromosome.
// Optional LANE_WEIGHT_EN applies a per-lane left shift (sampled with the sums) during accumulation.
module population_fitness_evaluator #(
  parameter int POP_SIZE = 16,
  parameter int IDX_W    = 4,
  parameter int SUM_W    = 32,
  parameter int FIT_W    = 38
) (
  input  logic                  iClock,
  input  logic                  iReset_n,
  input  logic                  iStartGeneration,
  input  logic [7:0]            iOutputMask,
  input  logic [7:0][1:0]       iLaneShift,
  input  logic                  iReadyToProcess,
  input  logic                  iDoneProcessing,
  input  logic [7:0][SUM_W-1:0] iErrorSums,
  output logic                  oStartProcessing,
  output logic                  oDoneFeedback,
  output logic [IDX_W-1:0]      oChromIndex,
  output logic                  oBusy,
  output logic [FIT_W-1:0]      oFitness,
  output logic                  oFitnessValid,
  output logic [IDX_W-1:0]      oBestIndex,
  output logic [FIT_W-1:0]      oBestFitness,
  output logic                  oGenerationDone
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, ACCUM, UPDATE, ACK, FINISH} state_t;
  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q, best_idx_q;
  logic [2:0]              lane_q;
  logic [FIT_W-1:0]        acc_q, fit_q, best_fit_q, lane_add_d;
  logic [7:0][SUM_W-1:0]   sums_q;
  logic [7:0]              mask_q;
  logic                    fit_valid_q;
  logic                    last_chrom;
`ifdef LANE_WEIGHT_EN
  logic [7:0][1:0]         shift_q;
  assign lane_add_d = mask_q[lane_q] ? FIT_W'(sums_q[lane_q]) << shift_q[lane_q] : '0;
`else
  logic                    unused_shift;
  assign unused_shift = ^iLaneShift;
  assign lane_add_d = mask_q[lane_q] ? FIT_W'(sums_q[lane_q]) : '0;
`endif
  assign last_chrom       = idx_q == IDX_W'(POP_SIZE - 1);
  assign oStartProcessing = state_q == ISSUE && iReadyToProcess;
  assign oDoneFeedback    = state_q == ACK;
  assign oGenerationDone  = state_q == FINISH;
  assign oBusy            = state_q != IDLE;
  assign oChromIndex      = idx_q;
  assign oFitness         = fit_q;
  assign oFitnessValid    = fit_valid_q;
  assign oBestIndex       = best_idx_q;
  assign oBestFitness     = best_fit_q;
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lane_q      <= '0;
      acc_q       <= '0;
      fit_q       <= '0;
      fit_valid_q <= 1'b0;
      best_idx_q  <= '0;
      best_fit_q  <= '1;
      sums_q      <= '0;
      mask_q      <= '0;
`ifdef LANE_WEIGHT_EN
      shift_q     <= '0;
`endif
    end else begin
      fit_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (iStartGeneration) begin
          state_q    <= ISSUE;
          idx_q      <= '0;
          best_idx_q <= '0;
          best_fit_q <= '1;
        end
        ISSUE: if (iReadyToProcess) state_q <= WAIT_DONE;
        WAIT_DONE: if (iDoneProcessing) begin
          sums_q  <= iErrorSums;
          mask_q  <= iOutputMask;
`ifdef LANE_WEIGHT_EN
          shift_q <= iLaneShift;
`endif
          acc_q   <= '0;
          lane_q  <= '0;
          state_q <= ACCUM;
        end
        ACCUM: begin
          acc_q  <= acc_q + lane_add_d;
          lane_q <= lane_q + 3'd1;
          if (lane_q == 3'd7) state_q <= UPDATE;
        end
        UPDATE: begin
          fit_q       <= acc_q;
          fit_valid_q <= 1'b1;
          // strict compare: an equal later fitness never displaces the earlier, lower index
          if (acc_q < best_fit_q) begin
            best_fit_q <= acc_q;
            best_idx_q <= idx_q;
          end
          state_q <= ACK;
        end
        ACK: begin
          state_q <= last_chrom ? FINISH : ISSUE;
          if (!last_chrom) idx_q <= idx_q + 1'b1;
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_population_fitness_evaluator.sv
// tb_population_fitness_evaluator: directed generations with hand-computed fitness and best results.
module tb_population_fitness_evaluator;
  localparam int SUM_W = 32;
  localparam int FIT_W = 38;
  localparam int IDX_W = 2;
  localparam logic [FIT_W-1:0] ONES = '1;
`ifdef LANE_WEIGHT_EN
  localparam logic [FIT_W-1:0] WF = 38'd15;
`else
  localparam logic [FIT_W-1:0] WF = 38'd8;
`endif
  logic iClock = 0, iReset_n = 0, iStartGeneration = 0, iReadyToProcess = 0, iDoneProcessing = 0;
  logic [7:0] iOutputMask = '0;
  logic [7:0][1:0] iLaneShift = '0;
  logic [7:0][SUM_W-1:0] iErrorSums = '0;
  logic oStartProcessing, oDoneFeedback, oBusy, oFitnessValid, oGenerationDone;
  logic [IDX_W-1:0] oChromIndex, oBestIndex;
  logic [FIT_W-1:0] oFitness, oBestFitness;
  int checks = 0, errors = 0, n_start = 0, n_fb = 0, n_gd = 0;
  logic [FIT_W-1:0] fits[$];
  logic [SUM_W-1:0] gv0[4], gv[4];
  logic [FIT_W-1:0] gef[4];

  population_fitness_evaluator #(.POP_SIZE(4), .IDX_W(IDX_W), .SUM_W(SUM_W), .FIT_W(FIT_W)) dut (
    .iClock(iClock), .iReset_n(iReset_n), .iStartGeneration(iStartGeneration),
    .iOutputMask(iOutputMask), .iLaneShift(iLaneShift), .iReadyToProcess(iReadyToProcess),
    .iDoneProcessing(iDoneProcessing), .iErrorSums(iErrorSums),
    .oStartProcessing(oStartProcessing), .oDoneFeedback(oDoneFeedback), .oChromIndex(oChromIndex),
    .oBusy(oBusy), .oFitness(oFitness), .oFitnessValid(oFitnessValid), .oBestIndex(oBestIndex),
    .oBestFitness(oBestFitness), .oGenerationDone(oGenerationDone));

  always #5 iClock = ~iClock;

  always @(negedge iClock) begin
    if (oStartProcessing) n_start++;
    if (oDoneFeedback) n_fb++;
    if (oGenerationDone) n_gd++;
    if (oFitnessValid) fits.push_back(oFitness);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic serve(input int c, input logic [SUM_W-1:0] v0, input logic [SUM_W-1:0] v, input logic [7:0] m);
    int n = 0;
    iReadyToProcess = 1;
    #1;
    while (!oStartProcessing && n < 100) begin tick(); n++; end
    check("start_seen", {63'd0, oStartProcessing}, 1);
    check("idx_issue", {62'd0, oChromIndex}, c);
    tick();
    iReadyToProcess = 0;
    iOutputMask = m;
    iErrorSums = {{7{v}}, v0};
    iDoneProcessing = 1;
    tick();
    iErrorSums = {8{32'h0100_0000}};
    iOutputMask = 8'hFF;
    repeat (3) tick();
    iDoneProcessing = 0;
    n = 0;
    while (!oDoneFeedback && n < 30) begin tick(); n++; end
    check("feedback_seen", {63'd0, oDoneFeedback}, 1);
    check("idx_ack", {62'd0, oChromIndex}, c);
    tick();
  endtask

  task automatic run_gen(input logic [7:0] m, input int ebi, input logic [FIT_W-1:0] ebf, input bit stall);
    int s0 = n_start, f0 = n_fb, g0 = n_gd, b0 = fits.size(), n = 0;
    iStartGeneration = 1;
    tick();
    iStartGeneration = 0;
    check("busy_start", {63'd0, oBusy}, 1);
    check("best_init", {26'd0, oBestFitness}, {26'd0, ONES});
    if (stall) begin
      iStartGeneration = 1;
      iDoneProcessing = 1;
      repeat (50) tick();
      iStartGeneration = 0;
      iDoneProcessing = 0;
      check("stall_start", n_start - s0, 0);
      check("stall_idx", {62'd0, oChromIndex}, 0);
      iReadyToProcess = 1;
      #1;
      check("start_on_rise", {63'd0, oStartProcessing}, 1);
    end
    for (int c = 0; c < 4; c++) serve(c, gv0[c], gv[c], m);
    while (oBusy && n < 20) begin tick(); n++; end
    check("busy_end", {63'd0, oBusy}, 0);
    check("n_start", n_start - s0, 4);
    check("n_feedback", n_fb - f0, 4);
    check("n_gen_done", n_gd - g0, 1);
    check("n_fitness", fits.size() - b0, 4);
    for (int c = 0; c < 4; c++)
      check("fitness", {26'd0, (fits.size() > b0 + c) ? fits[b0 + c] : ONES}, {26'd0, gef[c]});
    check("best_index", {62'd0, oBestIndex}, ebi);
    check("best_fitness", {26'd0, oBestFitness}, {26'd0, ebf});
  endtask

  initial begin
    repeat (2) tick();
    check("rst_busy", {63'd0, oBusy}, 0);
    check("rst_fitness", {26'd0, oFitness}, 0);
    check("rst_best_fit", {26'd0, oBestFitness}, {26'd0, ONES});
    check("rst_best_idx", {62'd0, oBestIndex}, 0);
    check("rst_idx", {62'd0, oChromIndex}, 0);
    check("rst_valid", {63'd0, oFitnessValid}, 0);
    check("rst_start", {63'd0, oStartProcessing}, 0);
    check("rst_gen_done", {63'd0, oGenerationDone}, 0);
    iReset_n = 1;
    tick();
    gv0 = '{1, 5, 2, 3}; gv = '{1, 5, 2, 3}; gef = '{8, 40, 16, 24};
    run_gen(8'hFF, 0, 8, 1);
    gv0 = '{7, 7, 7, 7}; gv = '{100, 100, 100, 100}; gef = '{7, 7, 7, 7};
    run_gen(8'h01, 0, 7, 0);
    gv0 = '{3, 2, 5, 9}; gv = '{10, 4, 1, 9}; gef = '{13, 6, 6, 18};
    run_gen(8'h81, 1, 6, 0);
    iLaneShift[0] = 2'd3;
    gv0 = '{1, 1, 1, 1}; gv = '{1, 1, 1, 1}; gef = '{WF, WF, WF, WF};
    run_gen(8'hFF, 0, WF, 0);
    iLaneShift = '0;
    iStartGeneration = 1;
    tick();
    iStartGeneration = 0;
    iReadyToProcess = 1;
    tick();
    iReadyToProcess = 0;
    iErrorSums = {8{32'd9}};
    iDoneProcessing = 1;
    tick();
    iDoneProcessing = 0;
    repeat (2) tick();
    check("pre_reset_busy", {63'd0, oBusy}, 1);
    #2 iReset_n = 0;
    #1;
    check("mid_rst_busy", {63'd0, oBusy}, 0);
    check("mid_rst_fitness", {26'd0, oFitness}, 0);
    check("mid_rst_best_fit", {26'd0, oBestFitness}, {26'd0, ONES});
    check("mid_rst_idx", {62'd0, oChromIndex}, 0);
    tick();
    iReset_n = 1;
    tick();
    gv0 = '{1, 5, 2, 3}; gv = '{1, 5, 2, 3}; gef = '{8, 40, 16, 24};
    run_gen(8'hFF, 0, 8, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
